demux_rr_ctrl: RTL and testbench
================================

# demux_rr_ctrl

Dispatch controller for the 1-to-4 demultiplexer. It accepts words on a valid/ready input stream and holds each one in a single holding register. It drives the demux select and a one-hot valid to the four destinations, and releases each word on that destination's ready. Destinations are chosen round-robin or fixed by configuration. In round-robin mode a word stalled on a non-ready destination is re-routed to the next destination after a timeout.

## Interface
- WIDTH, 8: data width.
- TIMEOUT, 15: stalled cycles before re-route in round-robin mode; 0 disables re-routing; legal range 0–255.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input word present.
- in_data  input  WIDTH  input word.
- in_ready  output  1  controller can accept a word this cycle.
- mode  input  1  0 = round-robin, 1 = fixed; sampled only on accept.
- cfg_sel  input  2  destination used in fixed mode; sampled only on accept.
- out_ready  input  4  per-destination ready.
- out_valid  output  4  one-hot valid to the destination selected by sel; all zero when empty.
- out_data  output  WIDTH  held word, shared by all destinations.
- sel  output  2  current destination index; drives the demux select (00→0, 01→1, 10→2, 11→3).
- skip_cnt  output  8  number of re-routes since reset; saturates at 255.

## Operation
- State: `held` (1 bit), `data` (WIDTH bits), `dest` (2 bits), `ptr` (2 bits, next round-robin destination), `word_rr` (mode of the held word), `stall` (8-bit counter), `skip_cnt`.
- Reset values:
  - `held` = 0, `data` = 0, `dest` = 0, `ptr` = 0, `word_rr` = 0, `stall` = 0, `skip_cnt` = 0.
  - Outputs: out_valid = 0000, out_data = 0, sel = 00, in_ready = 1 (combinational from state, so 1 during reset).
- `done` = held & out_ready[dest].
- in_ready = !held | done. Pass-through allows back-to-back words with no bubble.
- Accept (in_valid & in_ready):
  - data ← in_data.
  - held ← 1.
  - word_rr ← !mode.
  - stall ← 0.
  - In round-robin mode: dest ← ptr and ptr ← ptr+1 (mod 4; 3 wraps to 0).
  - In fixed mode: dest ← cfg_sel; ptr is unchanged.
- Complete: on `done` without accept, held ← 0. data and dest keep their last values, so sel keeps showing the last destination.
- Stall: when held & !out_ready[dest], stall increments.
- Re-route, when all of the following hold: word_rr = 1, TIMEOUT ≠ 0, held & !out_ready[dest], and stall = TIMEOUT−1.
  - dest ← dest+1 (mod 4).
  - stall ← 0.
  - skip_cnt increments unless it is already 255.
  - ptr is unchanged.
  - A fixed-mode word never re-routes; it waits indefinitely.
- out_valid = held ? onehot(dest) : 0.
- out_data = data; sel = dest.
- mode and cfg_sel changes while a word is held do not affect that word.
- in_data is ignored when in_valid = 0. out_ready bits other than out_ready[dest] are ignored.

## Timing
- Latency: a word accepted at edge N appears on out_valid/out_data/sel from cycle N+1.
- Throughput: one word per cycle when the destination is always ready.
- Handshake:
  - Completion happens at the edge where out_valid[dest] & out_ready[dest].
  - out_valid and out_data are stable while stalled, except at a re-route edge, where only sel/out_valid move.
- Accept and complete at the same edge: the new word replaces the old one; out_valid stays asserted (for the new dest) with no gap.
- Re-route occurs after exactly TIMEOUT consecutive stalled cycles. The word is presented on the next destination from the following cycle.
- If out_ready[dest] rises in the same cycle stall reaches TIMEOUT−1, completion wins and there is no re-route.
- Reset mid-operation: the held word is discarded, outputs go to reset values immediately (asynchronous), and round-robin restarts at destination 0.

## Test plan
- Round-robin, all ready: reset; send A1, A2, A3, A4, A5 back-to-back with out_ready = 1111.
  - Each word appears one cycle after acceptance.
  - sel = 0, 1, 2, 3, 0; out_valid = 0001, 0010, 0100, 1000, 0001.
  - in_ready stays 1.
- Fixed mode: mode = 1, cfg_sel = 10; send 3 words, then change cfg_sel while a word is held.
  - All 3 words go to out_valid = 0100.
  - The held word's sel does not change.
  - ptr does not move: the next round-robin word goes to dest 0.
- Backpressure: round-robin, out_ready = 0000, TIMEOUT = 0; send 0x5A.
  - out_valid = 0001 and out_data = 0x5A are held stable; in_ready = 0.
  - Raising out_ready[0] completes the word at that edge and in_ready returns to 1.
- Re-route: TIMEOUT = 3, round-robin, out_ready = 0000; send one word.
  - sel = 0 for 3 cycles, then 1 for 3 cycles, then 2, and so on.
  - skip_cnt increments at each move.
  - Setting out_ready = 0100 completes the word at dest 2.
  - In fixed mode under the same conditions, the word never moves.
- Simultaneous accept, complete and wrap: ptr = 3, hold a word at dest 2 with out_ready = 0100, and present a new word in the same cycle.
  - The new word goes to dest 3 with no out_valid gap.
  - The next word goes to dest 0.
- Asynchronous reset while holding a stalled word: out_valid = 0000, sel = 00, skip_cnt = 0 immediately.
  - The first word after release goes to dest 0.

Source files
------------

// File: rtl/demux_rr_ctrl.sv
// Dispatch controller for a 1-to-4 demux: one holding register, round-robin or fixed
// destination choice, and timeout re-routing of stalled round-robin words.
module demux_rr_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             mode,
    input  logic [1:0]       cfg_sel,
    input  logic [3:0]       out_ready,
    output logic [3:0]       out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic [7:0]       skip_cnt
);

    localparam bit         REROUTE_EN = (TIMEOUT != 0);
    localparam logic [7:0] STALL_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic             held;
    logic [WIDTH-1:0] data;
    logic [1:0]       dest;
    logic [1:0]       ptr;
    logic             word_rr;
    logic [7:0]       stall;
    logic [7:0]       skip_q;

    logic done;
    logic accept;
    logic stalled;
    logic reroute;

    // Valid/ready: a word moves on any edge where both sides are high; a held word
    // completes when its current destination is ready, freeing the register that edge.
    assign done     = held & out_ready[dest];
    assign in_ready = !held | done;
    assign accept   = in_valid & in_ready;
    assign stalled  = held & !out_ready[dest];
    assign reroute  = REROUTE_EN & word_rr & stalled & (stall == STALL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held    <= 1'b0;
            data    <= '0;
            dest    <= 2'd0;
            ptr     <= 2'd0;
            word_rr <= 1'b0;
            stall   <= 8'd0;
            skip_q  <= 8'd0;
        end else if (accept) begin
            data    <= in_data;
            held    <= 1'b1;
            word_rr <= !mode;
            stall   <= 8'd0;
            if (!mode) begin
                dest <= ptr;
                ptr  <= ptr + 2'd1;
            end else begin
                dest <= cfg_sel;
            end
        end else if (done) begin
            // data and dest are left alone so sel keeps the last destination.
            held <= 1'b0;
        end else if (reroute) begin
            dest  <= dest + 2'd1;
            stall <= 8'd0;
            if (skip_q != 8'hFF) begin
                skip_q <= skip_q + 8'd1;
            end
        end else if (stalled) begin
            stall <= stall + 8'd1;
        end
    end

    assign out_valid = held ? (4'b0001 << dest) : 4'b0000;
    assign out_data  = data;
    assign sel       = dest;
    assign skip_cnt  = skip_q;

endmodule

// File: tb/tb_demux_rr_ctrl.sv
// Directed bench for demux_rr_ctrl: a stimulus process queues expected {dest, data} per
// word, and a monitor pops and checks each time a destination takes a word.
module tb_demux_rr_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mode;
    logic [1:0] cfg_sel;
    logic [3:0] out_ready;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [1:0] sel;
    logic [7:0] skip_cnt;

    logic       b_in_valid;
    logic [7:0] b_in_data;
    logic       b_in_ready;
    logic       b_mode;
    logic [1:0] b_cfg_sel;
    logic [3:0] b_out_ready;
    logic [3:0] b_out_valid;
    logic [7:0] b_out_data;
    logic [1:0] b_sel;
    logic [7:0] b_skip_cnt;

    logic [9:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    demux_rr_ctrl #(.WIDTH(8), .TIMEOUT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mode(mode), .cfg_sel(cfg_sel), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .sel(sel), .skip_cnt(skip_cnt)
    );

    demux_rr_ctrl #(.WIDTH(8), .TIMEOUT(0)) dut_nt (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .mode(b_mode), .cfg_sel(b_cfg_sel), .out_ready(b_out_ready), .out_valid(b_out_valid),
        .out_data(b_out_data), .sel(b_sel), .skip_cnt(b_skip_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: present one word and hold it until accepted
    task automatic send(input logic [7:0] d, input logic m, input logic [1:0] c,
                        input bit ready_now);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        cfg_sel  = c;
        n = 0;
        @(negedge clk);
        if (ready_now) chk("in_ready_now", 32'(in_ready), 32'd1);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst && ((out_valid & out_ready) != 4'b0000)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_sel", 32'(sel), 32'(e[9:8]));
                chk("sb_data", 32'(out_data), 32'(e[7:0]));
                chk("sb_out_valid", 32'(out_valid), 32'(4'b0001 << e[9:8]));
            end
        end
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rr_sel[8];
        logic [7:0] rr_skip[8];
        rr_sel  = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
        rr_skip = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2};

        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; mode = 1'b0; cfg_sel = 2'd0; out_ready = 4'b1111;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_mode = 1'b0; b_cfg_sel = 2'd0;
        b_out_ready = 4'b0000;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_skip", 32'(skip_cnt), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Backpressure with re-routing disabled: word waits on dest 0 indefinitely.
        b_in_valid = 1'b1; b_in_data = 8'h5A; b_mode = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_first", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_in_data = 8'hC3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(b_out_valid), 32'b0001);
            chk("bp_out_data", 32'(b_out_data), 32'h5A);
            chk("bp_in_ready", 32'(b_in_ready), 32'd0);
            chk("bp_skip", 32'(b_skip_cnt), 32'd0);
        end
        @(posedge clk); #1;
        b_out_ready = 4'b0001;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_done_out_valid", 32'(b_out_valid), 32'd0);
        chk("bp_done_in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk); #1;

        // Round-robin, all ready, back-to-back.
        out_ready = 4'b1111;
        exp_q.push_back({2'd0, 8'hA1}); send(8'hA1, 1'b0, 2'd0, 1'b1);
        exp_q.push_back({2'd1, 8'hA2}); send(8'hA2, 1'b0, 2'd0, 1'b1);
        exp_q.push_back({2'd2, 8'hA3}); send(8'hA3, 1'b0, 2'd0, 1'b1);
        exp_q.push_back({2'd3, 8'hA4}); send(8'hA4, 1'b0, 2'd0, 1'b1);
        exp_q.push_back({2'd0, 8'hA5}); send(8'hA5, 1'b0, 2'd0, 1'b1);
        idle(2);

        // Fixed mode to dest 2; ptr stays at 1.
        exp_q.push_back({2'd2, 8'hF1}); send(8'hF1, 1'b1, 2'd2, 1'b1);
        exp_q.push_back({2'd2, 8'hF2}); send(8'hF2, 1'b1, 2'd2, 1'b1);
        exp_q.push_back({2'd2, 8'hF3}); send(8'hF3, 1'b1, 2'd2, 1'b1);
        idle(1);
        out_ready = 4'b0000;
        exp_q.push_back({2'd2, 8'hF4}); send(8'hF4, 1'b1, 2'd2, 1'b1);
        cfg_sel = 2'd1; mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("fx_hold_sel", 32'(sel), 32'd2);
            chk("fx_hold_valid", 32'(out_valid), 32'b0100);
            chk("fx_hold_skip", 32'(skip_cnt), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 4'b0100;
        idle(1);
        out_ready = 4'b1111;
        exp_q.push_back({2'd1, 8'h77}); send(8'h77, 1'b0, 2'd3, 1'b1);
        idle(2);

        // Re-route every 3 stalled cycles; completion wins at stall = TIMEOUT-1.
        out_ready = 4'b0000;
        exp_q.push_back({2'd0, 8'hB0}); send(8'hB0, 1'b0, 2'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_sel", 32'(sel), 32'(rr_sel[i]));
            chk("rr_skip", 32'(skip_cnt), 32'(rr_skip[i]));
            chk("rr_data", 32'(out_data), 32'hB0);
        end
        @(posedge clk); #1;
        out_ready = 4'b0001;
        idle(1);
        @(negedge clk);
        chk("rr_after_skip", 32'(skip_cnt), 32'd2);
        chk("rr_after_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Accept + complete in the same edge, with ptr wrapping 3 -> 0.
        out_ready = 4'b0000;
        exp_q.push_back({2'd2, 8'hC1}); send(8'hC1, 1'b1, 2'd2, 1'b1);
        out_ready = 4'b0100;
        exp_q.push_back({2'd3, 8'hD1}); send(8'hD1, 1'b0, 2'd0, 1'b1);
        @(negedge clk);
        chk("ov_no_gap", 32'(out_valid), 32'b1000);
        chk("ov_sel", 32'(sel), 32'd3);
        @(posedge clk); #1;
        out_ready = 4'b1000;
        exp_q.push_back({2'd0, 8'hE1}); send(8'hE1, 1'b0, 2'd0, 1'b1);
        @(negedge clk);
        chk("wrap_valid", 32'(out_valid), 32'b0001);
        @(posedge clk); #1;
        out_ready = 4'b1111;
        idle(2);

        // Asynchronous reset while a word is stalled.
        out_ready = 4'b0000;
        send(8'h99, 1'b0, 2'd0, 1'b1);
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_skip", 32'(skip_cnt), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 4'b1111;
        exp_q.push_back({2'd0, 8'h42}); send(8'h42, 1'b0, 2'd0, 1'b1);
        idle(3);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
